kbd_rx_fifo: RTL
================

# kbd_rx_fifo

PS/2 keyboard receiver that turns the two-wire `kbd` bus (`kbd[0]` = PS/2 clock, `kbd[1]` = PS/2 data) into a stream of 8-bit scan codes buffered in a parametrised FIFO. It generalises the fixed single-byte keyboard capture with input glitch filtering, frame timeout, parity/stop checking and a valid/ready output. It sits between the board `kbd` pins and the CPU I/O register file inside `top`.

## Interface
- `FILTER_LEN`, 4, consecutive identical samples needed before a filtered `kbd` line changes (2..16)
- `FIFO_DEPTH`, 8, scan-code FIFO entries, power of two, 2..64
- `TIMEOUT_CYCLES`, 50000, `clk` cycles without a PS/2 falling edge before an open frame is aborted
- `clk`  input  1  system clock
- `rst_n`  input  1  reset; one clock; reset is asynchronous and active-low
- `kbd`  input  2  raw PS/2 lines, `[0]` clock, `[1]` data, asynchronous to `clk`
- `code_data`  output  8  FIFO head scan code
- `code_valid`  output  1  FIFO non-empty
- `code_ready`  input  1  consumer accepts head when high with `code_valid`
- `fifo_count`  output  $clog2(FIFO_DEPTH)+1  entries held
- `overflow`  output  1  sticky: a good frame was dropped because FIFO was full
- `clr_ovf`  input  1  synchronous clear of `overflow`
- `frame_err`  output  1  one-cycle pulse on bad start/parity/stop or timeout

## Operation
- Both `kbd` bits pass a 2-flop synchroniser, then a per-line filter: filtered value updates to the synchronised value after `FILTER_LEN` consecutive equal samples. Filtered lines reset to 1.
- Falling edge of filtered clock = sample strobe.
- FSM states IDLE, DATA, PARITY, STOP:
  - IDLE: on strobe, data=0 → DATA, bit counter 0; data=1 → stay (spurious, no error).
  - DATA: on strobe shift data into bit 7 of shift register (LSB first); after 8th bit → PARITY.
  - PARITY: on strobe latch parity bit → STOP.
  - STOP: on strobe, if stop=1 and parity check passes → push byte; else `frame_err` pulse. Always → IDLE.
- Timeout counter clears on every strobe and in IDLE; in DATA/PARITY/STOP reaching `TIMEOUT_CYCLES` → IDLE, `frame_err` pulse, partial byte discarded.
- FIFO: push when not full; push while full and no pop → byte dropped, `overflow` set. Push and pop same cycle while full → both accepted, count unchanged. Pop when `code_valid && code_ready`. Pointers wrap modulo `FIFO_DEPTH`.
- `clr_ovf` and a same-cycle overflow event: set wins.

## Timing
- Reset values: `code_data` 0, `code_valid` 0, `fifo_count` 0, `overflow` 0, `frame_err` 0; FSM IDLE, counters 0, FIFO emptied.
- Raw `kbd[0]` fall to strobe: 2 + `FILTER_LEN` + 1 cycles (stable input).
- Stop-bit strobe → push registered next edge; `code_valid` high and `fifo_count` incremented that same edge.
- `code_data` is registered from FIFO memory and valid whenever `code_valid`=1; after a pop the new head appears the next cycle with no bubble.
- `rst_n` asserted mid-frame: frame lost, no `frame_err`.

## Configuration
- `KBD_RX_PARITY_EN` defined: odd parity checked (data bits + parity bit must have odd count of 1s); failure → no push, `frame_err`.
- Undefined: parity bit sampled and ignored; only start and stop are checked.

## Structure
- Shared package `kbd_pkg`: FSM state enum (IDLE, DATA, PARITY, STOP), `KBD_CODE_W = 8`, scan-code constants `KBD_BREAK = 8'hF0`, `KBD_EXT = 8'hE0`.
- One sub-module `kbd_line_filter` (synchroniser + filter, parameter `FILTER_LEN`), instantiated twice; FIFO kept inline.

## Test plan
Params FILTER_LEN=4, FIFO_DEPTH=4, TIMEOUT_CYCLES=1000; PS/2 bit period 200 cycles.
- Frame 0x1C, correct odd parity, stop=1, `code_ready`=0 → `code_valid`=1, `code_data`=0x1C, `fifo_count`=1, no `frame_err`.
- Frames 0xF0, 0x1C, 0xE0, 0x75, 0x29 with `code_ready`=0 → count 4, `overflow`=1; then `code_ready`=1 drains 0xF0,0x1C,0xE0,0x75 in four consecutive cycles; `clr_ovf` → `overflow`=0.
- Frame 0x1C with wrong parity → with `KBD_RX_PARITY_EN`: `frame_err` pulse, count 0; without: 0x1C pushed.
- Frame with stop=0 → one `frame_err` pulse, no push.
- Five clock pulses then lines held high 1500 cycles → `frame_err` at cycle ~1000 after last edge; following good frame 0x29 received correctly.
- 2-cycle low glitches on `kbd[0]` in IDLE → no strobe, no state change, no error.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared definitions for the PS/2 keyboard receiver.
//   kbd_state_t  - frame FSM state encoding
//   KBD_CODE_W   - scan-code width
//   KBD_BREAK    - key-release prefix code
//   KBD_EXT      - extended-key prefix code
package kbd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } kbd_state_t;

   localparam int KBD_CODE_W = 8;

   localparam logic [KBD_CODE_W-1:0] KBD_BREAK = 8'hF0;
   localparam logic [KBD_CODE_W-1:0] KBD_EXT   = 8'hE0;

endpackage

// File: rtl/kbd_line_filter.sv
// kbd_line_filter: two-flop synchroniser followed by a run-length glitch
// filter for one PS/2 line. The filtered output only follows the synchronised
// value once FILTER_LEN consecutive samples disagree with the current output.
//   clk, rst_n  - system clock, asynchronous active-low reset
//   raw         - asynchronous PS/2 line
//   filt        - synchronised, filtered line (resets to 1, the idle level)
module kbd_line_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic filt
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] RUN_LOAD = CW'(FILTER_LEN - 1);

   logic          sync_q1;
   logic          sync_q2;
   logic [CW-1:0] run_cnt;

   // run_cnt counts down the samples still needed; any sample that agrees
   // with the current output restarts the run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
         run_cnt <= RUN_LOAD;
         filt    <= 1'b1;
      end else begin
         sync_q1 <= raw;
         sync_q2 <= sync_q1;
         if (sync_q2 == filt) begin
            run_cnt <= RUN_LOAD;
         end else if (run_cnt == '0) begin
            filt    <= sync_q2;
            run_cnt <= RUN_LOAD;
         end else begin
            run_cnt <= run_cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/kbd_rx_fifo.sv
// kbd_rx_fifo: PS/2 keyboard receiver with frame checking and a scan-code FIFO.
//   clk, rst_n  - system clock, asynchronous active-low reset
//   kbd[1:0]    - raw PS/2 lines, [0] clock, [1] data
//   code_data   - FIFO head scan code (valid while code_valid)
//   code_valid  - FIFO non-empty
//   code_ready  - consumer pops the head when high with code_valid
//   fifo_count  - entries held
//   overflow    - sticky, a good frame was dropped on a full FIFO
//   clr_ovf     - synchronous clear of overflow (a same-cycle drop wins)
//   frame_err   - one-cycle pulse on bad start/parity/stop or timeout
// Build option: define KBD_RX_PARITY_EN to enforce odd parity; otherwise the
// parity bit is sampled and ignored.
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on clock fall)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | waiting for the parity bit
// STOP   | waiting for the stop bit; push or flag error, then back to IDLE
module kbd_rx_fifo
   import kbd_pkg::*;
#(
   parameter int FILTER_LEN     = 4,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [1:0]                    kbd,
   output logic [KBD_CODE_W-1:0]         code_data,
   output logic                          code_valid,
   input  logic                          code_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   input  logic                          clr_ovf,
   output logic                          frame_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

   logic ps2_clk_f;
   logic ps2_dat_f;
   logic ps2_clk_d1;
   logic strobe_q;

   kbd_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (kbd[0]),
      .filt  (ps2_clk_f)
   );

   kbd_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (kbd[1]),
      .filt  (ps2_dat_f)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps2_clk_d1 <= 1'b1;
         strobe_q   <= 1'b0;
      end else begin
         ps2_clk_d1 <= ps2_clk_f;
         strobe_q   <= ps2_clk_d1 & ~ps2_clk_f;
      end
   end

   kbd_state_t            state;
   logic [2:0]            bit_cnt;
   logic [KBD_CODE_W-1:0] shift_q;
   logic [TW-1:0]         tmo_cnt;
   logic                  push_q;
   logic [KBD_CODE_W-1:0] push_data;
   logic                  par_ok;

`ifdef KBD_RX_PARITY_EN
   logic par_q;
   assign par_ok = ^{shift_q, par_q};
`else
   assign par_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_q   <= '0;
         tmo_cnt   <= TMO_LOAD;
         push_q    <= 1'b0;
         push_data <= '0;
         frame_err <= 1'b0;
`ifdef KBD_RX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         push_q    <= 1'b0;
         frame_err <= 1'b0;
         if (state == IDLE) begin
            tmo_cnt <= TMO_LOAD;
            if (strobe_q && !ps2_dat_f) begin
               state   <= DATA;
               bit_cnt <= '0;
            end
         end else if (strobe_q) begin
            tmo_cnt <= TMO_LOAD;
            unique case (state)
               DATA: begin
                  shift_q <= {ps2_dat_f, shift_q[KBD_CODE_W-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
`ifdef KBD_RX_PARITY_EN
                  par_q <= ps2_dat_f;
`endif
                  state <= STOP;
               end
               STOP: begin
                  if (ps2_dat_f && par_ok) begin
                     push_q    <= 1'b1;
                     push_data <= shift_q;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end else if (tmo_cnt == '0) begin
            // bus went quiet mid-frame: drop the partial byte
            state     <= IDLE;
            frame_err <= 1'b1;
         end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
         end
      end
   end

   logic [KBD_CODE_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW-1:0]         rd_next;
   logic [CW-1:0]         count_q;
   logic                  full;
   logic                  pop;
   logic                  push_ok;
   logic                  ovf_evt;

   assign code_valid = (count_q != '0);
   assign full       = (count_q == CW'(FIFO_DEPTH));
   assign pop        = code_valid & code_ready;
   // a pop frees a slot in the same cycle, so a full FIFO still accepts
   assign push_ok    = push_q & (~full | pop);
   assign ovf_evt    = push_q & full & ~pop;
   assign rd_next    = rd_ptr + 1'b1;
   assign fifo_count = count_q;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         code_data <= '0;
         overflow  <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_next;
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         // head register: prefetch the next entry on a pop, or take the
         // incoming byte directly when it becomes the new head
         if (pop) begin
            if (count_q > CW'(1))  code_data <= mem[rd_next];
            else if (push_ok)      code_data <= push_data;
         end else if (!code_valid && push_ok) begin
            code_data <= push_data;
         end
         if (ovf_evt)      overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

endmodule
